// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the boot-time IMEM loader.
//               Holds the loader state enum, the field sizes of the byte
//               stream, and a helper that decodes which states take bytes.
//               Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the
//               CSUM state for the trailing checksum field.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;   // bytes per IMEM data word
  localparam int LEN_BYTES  = 4;   // bytes in the leading word-count field

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    ST_CSUM = 3'd5
`endif
  } loader_state_t;

  // True for the states in which the stream handshake is open.
  function automatic logic accepts_bytes(input loader_state_t s);
    logic ok;
    ok = (s == ST_LEN) || (s == ST_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    ok = ok || (s == ST_CSUM);
`endif
    return ok;
  endfunction

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : word_packer
// Description : Little-endian byte-to-word assembler shared by the length,
//               data and checksum fields. Byte k of a word lands in bits
//               [8k+7:8k]. word/word_valid are combinational and are valid
//               in the cycle the 4th byte is accepted.
// Ports       : clk, rst (async, active-high)
//               clr        - restart byte counting at a field boundary
//               en         - a byte is transferred this cycle
//               din[7:0]   - transferred byte
//               word[31:0] - assembled word (valid with word_valid)
//               word_valid - 4th byte of a word is being accepted
// Revision    : 1.0 - initial release
// ============================================================================
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] c_last_byte = 2'(WORD_BYTES - 1);

  // Only the first three bytes need storage; the 4th is taken straight
  // from the input so the word is available in its transfer cycle.
  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (clr) begin
      r_cnt   <= '0;
    end else if (en) begin
      r_shift <= {din, r_shift[23:8]};
      r_cnt   <= r_cnt + 2'd1;   // wraps to 0 after the 4th byte
    end
  end

  assign word       = {din, r_shift};
  assign word_valid = en && (r_cnt == c_last_byte);

endmodule : word_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time program loader. Receives a LE byte stream
//               (word count N, then N data words), writes the words into
//               IMEM and holds the core in reset until the image is loaded.
//               Optional feature macro: IMEM_LOADER_CHECKSUM_EN - a trailing
//               32-bit checksum (mod-2^32 sum of data words) is required and
//               a mismatch ends in ERR.
// Ports       : clk, rst (async, active-high)
//               start                 - begin a load (IDLE/RUN/ERR only)
//               in_valid/in_data/in_ready - byte stream handshake
//               imem_we/imem_addr/imem_wdata - IMEM write port
//               core_rst              - core reset, high until loaded
//               done                  - image loaded, core running
//               error                 - load failed
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t c_after_data = ST_CSUM;
`else
  localparam loader_state_t c_after_data = ST_RUN;
`endif
  localparam logic [32:0] c_capacity = 33'd1 << ADDR_WIDTH;

  loader_state_t         r_state;
  loader_state_t         w_next;
  logic                  r_in_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_core_rst;
  logic                  r_done;
  logic                  r_error;
  // One bit wider than the address so N = 2^ADDR_WIDTH is representable.
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_wcnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]           r_sum;
`endif

  logic        w_xfer;
  logic        w_start_ok;
  logic [31:0] w_word;
  logic        w_word_valid;
  logic        w_len_ovf;
  logic        w_last_word;
  logic        w_data_word;

  assign w_xfer      = in_valid && r_in_ready;
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_RUN) ||
                                 (r_state == ST_ERR));
  assign w_len_ovf   = {1'b0, w_word} > c_capacity;
  assign w_last_word = (r_wcnt + 1'b1) == r_len;
  assign w_data_word = (r_state == ST_DATA) && w_word_valid;

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (w_start_ok),
    .en         (w_xfer),
    .din        (in_data),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) w_next = ST_LEN;
      end
      ST_LEN: begin
        if (w_word_valid) begin
          if (w_len_ovf)          w_next = ST_ERR;
          else if (w_word == '0)  w_next = c_after_data;
          else                    w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_valid && w_last_word) w_next = c_after_data;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (w_word_valid) w_next = (w_word == r_sum) ? ST_RUN : ST_ERR;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they change together
  // with the state itself (e.g. core_rst falls the cycle after the last
  // transfer).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_len      <= '0;
      r_wcnt     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_state    <= w_next;
      r_in_ready <= accepts_bytes(w_next);
      r_core_rst <= (w_next != ST_RUN);
      r_done     <= (w_next == ST_RUN);
      r_error    <= (w_next == ST_ERR);
      r_we       <= w_data_word;

      if ((r_state == ST_LEN) && w_word_valid) begin
        r_len <= w_word[ADDR_WIDTH:0];
      end

      if (w_data_word) begin
        r_addr  <= r_wcnt[ADDR_WIDTH-1:0];
        r_wdata <= w_word;
        r_wcnt  <= r_wcnt + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum   <= r_sum + w_word;
`endif
      end

      if (w_start_ok) begin
        r_wcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum  <= '0;
`endif
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_rst   = r_core_rst;
  assign done       = r_done;
  assign error      = r_error;

endmodule : imem_loader
`default_nettype wire
